// File: rtl/icache_dm.sv
// icache_dm: direct-mapped instruction cache, 16-byte lines (4 words).
// Fetch hits respond one cycle after acceptance. A miss pulses cache_miss,
// absorbs a 4-beat refill stream, installs the line and returns the
// requested word. Fetch is blocked while a refill is in progress.

`ifndef XLEN
`define XLEN 32
`endif

module icache_dm #(
    parameter int unsigned NUM_LINES = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             fetch_valid,
    input  logic [`XLEN-1:0] fetch_addr,
    output logic             fetch_ready,
    output logic             resp_valid,
    output logic [`XLEN-1:0] resp_data,
    input  logic             flush,
    output logic             cache_miss,
    output logic [`XLEN-1:0] miss_addr,
    input  logic             refill_valid,
    input  logic [`XLEN-1:0] refill_data,
    input  logic             refill_done
);

    localparam int unsigned IDX_BITS = $clog2(NUM_LINES);
    localparam int unsigned TAG_W    = `XLEN - IDX_BITS - 4;

    typedef enum logic {
        IDLE,
        REFILL
    } state_t;

    state_t state, state_nxt;

    // Line storage; only the valid bits need a defined reset value
    logic [NUM_LINES-1:0] valid_q;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [`XLEN-1:0]     data_q [NUM_LINES][4];

    // Refill bookkeeping
    logic [IDX_BITS-1:0]  lat_idx;
    logic [TAG_W-1:0]     lat_tag;
    logic [1:0]           lat_off;
    logic [1:0]           beat_cnt;
    logic [`XLEN-1:0]     crit_word;
    logic                 flush_pending;

    // Lookup fields of the incoming fetch address
    logic [1:0]           f_off;
    logic [IDX_BITS-1:0]  f_idx;
    logic [TAG_W-1:0]     f_tag;
    logic                 lookup_hit;

    // FSM decode strobes
    logic                 hit;
    logic                 miss;
    logic                 beat_wr;
    logic                 line_done;

    // Byte-offset bits of the fetch address are architecturally ignored
    logic                 unused_addr_lsbs;

    assign f_off            = fetch_addr[3:2];
    assign f_idx            = fetch_addr[IDX_BITS+3:4];
    assign f_tag            = fetch_addr[`XLEN-1:IDX_BITS+4];
    assign lookup_hit       = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    assign unused_addr_lsbs = &{1'b0, fetch_addr[1:0]};

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and per-cycle action decode
    always_comb begin
        state_nxt   = state;
        fetch_ready = 1'b0;
        hit         = 1'b0;
        miss        = 1'b0;
        beat_wr     = 1'b0;
        line_done   = 1'b0;
        case (state)
            IDLE: begin
                fetch_ready = reset;
                if (fetch_valid && fetch_ready) begin
                    if (lookup_hit) begin
                        hit = 1'b1;
                    end else begin
                        miss      = 1'b1;
                        state_nxt = REFILL;
                    end
                end
            end
            REFILL: begin
                // refill_done wins if both strobes ever coincide
                if (refill_done) begin
                    line_done = 1'b1;
                    state_nxt = IDLE;
                end else if (refill_valid) begin
                    beat_wr = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Response and miss-request outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            resp_valid <= 1'b0;
            resp_data  <= '0;
            cache_miss <= 1'b0;
            miss_addr  <= '0;
        end else begin
            resp_valid <= 1'b0;
            cache_miss <= 1'b0;
            if (hit) begin
                resp_valid <= 1'b1;
                resp_data  <= data_q[f_idx][f_off];
            end
            if (miss) begin
                cache_miss <= 1'b1;
                miss_addr  <= fetch_addr;
            end
            if (line_done) begin
                resp_valid <= 1'b1;
                resp_data  <= (lat_off == 2'd3) ? refill_data : crit_word;
            end
        end
    end

    // Miss context, beat counter and critical-word capture
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lat_idx       <= '0;
            lat_tag       <= '0;
            lat_off       <= '0;
            beat_cnt      <= '0;
            crit_word     <= '0;
            flush_pending <= 1'b0;
        end else begin
            if (miss) begin
                lat_idx  <= f_idx;
                lat_tag  <= f_tag;
                lat_off  <= f_off;
                beat_cnt <= '0;
            end
            if (beat_wr) begin
                beat_cnt <= beat_cnt + 2'd1;
                if (beat_cnt == lat_off) begin
                    crit_word <= refill_data;
                end
            end
            if (state == REFILL && flush && !line_done) begin
                flush_pending <= 1'b1;
            end
            if (line_done) begin
                beat_cnt      <= '0;
                flush_pending <= 1'b0;
            end
        end
    end

    // Valid bits: flush clears all; a completed refill validates its line
    // unless a flush was seen during (or on the final beat of) the refill
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
        end else if (flush) begin
            valid_q <= '0;
        end else if (line_done && !flush_pending) begin
            valid_q[lat_idx] <= 1'b1;
        end
    end

    // Tag and data arrays; the final beat lands in the slot the counter names
    always_ff @(posedge clk) begin
        if (beat_wr || line_done) begin
            data_q[lat_idx][beat_cnt] <= refill_data;
        end
        if (line_done) begin
            tag_q[lat_idx] <= lat_tag;
        end
    end

endmodule

// File: tb/tb_icache_dm.sv
// tb_icache_dm: directed self-checking bench for icache_dm.

`ifndef XLEN
`define XLEN 32
`endif

module tb_icache_dm;

    logic             clk;
    logic             reset;
    logic             fetch_valid;
    logic [`XLEN-1:0] fetch_addr;
    logic             fetch_ready;
    logic             resp_valid;
    logic [`XLEN-1:0] resp_data;
    logic             flush;
    logic             cache_miss;
    logic [`XLEN-1:0] miss_addr;
    logic             refill_valid;
    logic [`XLEN-1:0] refill_data;
    logic             refill_done;

    int total;
    int bad;

    icache_dm #(.NUM_LINES(64)) dut (
        .clk          (clk),
        .reset        (reset),
        .fetch_valid  (fetch_valid),
        .fetch_addr   (fetch_addr),
        .fetch_ready  (fetch_ready),
        .resp_valid   (resp_valid),
        .resp_data    (resp_data),
        .flush        (flush),
        .cache_miss   (cache_miss),
        .miss_addr    (miss_addr),
        .refill_valid (refill_valid),
        .refill_data  (refill_data),
        .refill_done  (refill_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle; inputs change and outputs are sampled 1ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a fetch for exactly one edge
    task automatic start_fetch(input logic [`XLEN-1:0] addr);
        fetch_valid = 1'b1;
        fetch_addr  = addr;
        tick();
        fetch_valid = 1'b0;
    endtask

    // Present one refill beat (done=1 for the final beat) for exactly one edge
    task automatic drive_beat(input logic done, input logic [`XLEN-1:0] data);
        refill_valid = ~done;
        refill_done  = done;
        refill_data  = data;
        tick();
        refill_valid = 1'b0;
        refill_done  = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
        #3;
        total++; if (fetch_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%0h exp=0", fetch_ready); end
        total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL rst_resp_valid got=%0h exp=0", resp_valid); end
        total++; if (resp_data !== 32'h0) begin bad++; $display("FAIL rst_resp_data got=%0h exp=0", resp_data); end
        total++; if (cache_miss !== 1'b0) begin bad++; $display("FAIL rst_cache_miss got=%0h exp=0", cache_miss); end
        total++; if (miss_addr !== 32'h0) begin bad++; $display("FAIL rst_miss_addr got=%0h exp=0", miss_addr); end
        tick();
        tick();
        reset = 1'b1;
        tick();
        total++; if (fetch_ready !== 1'b1) begin bad++; $display("FAIL rst_ready_idle got=%0h exp=1", fetch_ready); end
    endtask

    task automatic test_cold_miss();
        start_fetch(32'h0000_1008);
        total++; if (cache_miss !== 1'b1) begin bad++; $display("FAIL cold_miss_pulse got=%0h exp=1", cache_miss); end
        total++; if (miss_addr !== 32'h0000_1008) begin bad++; $display("FAIL cold_miss_addr got=%0h exp=1008", miss_addr); end
        total++; if (fetch_ready !== 1'b0) begin bad++; $display("FAIL cold_ready_refill got=%0h exp=0", fetch_ready); end
        total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL cold_no_resp got=%0h exp=0", resp_valid); end
        drive_beat(1'b0, 32'h11);
        total++; if (cache_miss !== 1'b0) begin bad++; $display("FAIL cold_miss_one_cycle got=%0h exp=0", cache_miss); end
        drive_beat(1'b0, 32'h22);
        drive_beat(1'b0, 32'h33);
        total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL cold_resp_early got=%0h exp=0", resp_valid); end
        drive_beat(1'b1, 32'h44);
        total++; if (resp_valid !== 1'b1) begin bad++; $display("FAIL cold_resp_valid got=%0h exp=1", resp_valid); end
        total++; if (resp_data !== 32'h33) begin bad++; $display("FAIL cold_resp_data got=%0h exp=33", resp_data); end
        total++; if (fetch_ready !== 1'b1) begin bad++; $display("FAIL cold_ready_after got=%0h exp=1", fetch_ready); end
        tick();
        total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL cold_resp_pulse got=%0h exp=0", resp_valid); end
    endtask

    task automatic test_back_to_back();
        fetch_valid = 1'b1;
        fetch_addr  = 32'h0000_1000;
        tick();
        total++; if (resp_valid !== 1'b1 || resp_data !== 32'h11) begin bad++; $display("FAIL b2b_w0 got=%0h/%0h exp=1/11", resp_valid, resp_data); end
        total++; if (cache_miss !== 1'b0) begin bad++; $display("FAIL b2b_w0_miss got=%0h exp=0", cache_miss); end
        fetch_addr = 32'h0000_1004;
        tick();
        total++; if (resp_valid !== 1'b1 || resp_data !== 32'h22) begin bad++; $display("FAIL b2b_w1 got=%0h/%0h exp=1/22", resp_valid, resp_data); end
        fetch_addr = 32'h0000_100C;
        tick();
        total++; if (resp_valid !== 1'b1 || resp_data !== 32'h44) begin bad++; $display("FAIL b2b_w3 got=%0h/%0h exp=1/44", resp_valid, resp_data); end
        total++; if (cache_miss !== 1'b0 || fetch_ready !== 1'b1) begin bad++; $display("FAIL b2b_w3_miss_ready got=%0h/%0h exp=0/1", cache_miss, fetch_ready); end
        fetch_valid = 1'b0;
        tick();
    endtask

    task automatic test_conflict();
        start_fetch(32'h0000_1400);
        total++; if (cache_miss !== 1'b1 || miss_addr !== 32'h0000_1400) begin bad++; $display("FAIL conf_miss got=%0h/%0h exp=1/1400", cache_miss, miss_addr); end
        drive_beat(1'b0, 32'hA0);
        drive_beat(1'b0, 32'hA1);
        drive_beat(1'b0, 32'hA2);
        drive_beat(1'b1, 32'hA3);
        total++; if (resp_valid !== 1'b1 || resp_data !== 32'hA0) begin bad++; $display("FAIL conf_resp got=%0h/%0h exp=1/a0", resp_valid, resp_data); end
        start_fetch(32'h0000_1404);
        total++; if (resp_valid !== 1'b1 || resp_data !== 32'hA1 || cache_miss !== 1'b0) begin bad++; $display("FAIL conf_hit got=%0h/%0h/%0h exp=1/a1/0", resp_valid, resp_data, cache_miss); end
        start_fetch(32'h0000_1000);
        total++; if (cache_miss !== 1'b1 || miss_addr !== 32'h0000_1000) begin bad++; $display("FAIL conf_evict got=%0h/%0h exp=1/1000", cache_miss, miss_addr); end
        total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL conf_evict_resp got=%0h exp=0", resp_valid); end
        drive_beat(1'b0, 32'h11);
        drive_beat(1'b0, 32'h22);
        drive_beat(1'b0, 32'h33);
        drive_beat(1'b1, 32'h44);
        total++; if (resp_valid !== 1'b1 || resp_data !== 32'h11) begin bad++; $display("FAIL conf_refill_resp got=%0h/%0h exp=1/11", resp_valid, resp_data); end
    endtask

    task automatic test_flush_refill();
        start_fetch(32'h0000_2004);
        total++; if (cache_miss !== 1'b1 || miss_addr !== 32'h0000_2004) begin bad++; $display("FAIL flr_miss got=%0h/%0h exp=1/2004", cache_miss, miss_addr); end
        drive_beat(1'b0, 32'hB0);
        tick();
        tick();
        total++; if (resp_valid !== 1'b0 || fetch_ready !== 1'b0) begin bad++; $display("FAIL flr_gap got=%0h/%0h exp=0/0", resp_valid, fetch_ready); end
        drive_beat(1'b0, 32'hB1);
        tick();
        tick();
        drive_beat(1'b0, 32'hB2);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        total++; if (resp_valid !== 1'b0 || fetch_ready !== 1'b0) begin bad++; $display("FAIL flr_gap_flush got=%0h/%0h exp=0/0", resp_valid, fetch_ready); end
        drive_beat(1'b1, 32'hB3);
        total++; if (resp_valid !== 1'b1 || resp_data !== 32'hB1) begin bad++; $display("FAIL flr_resp got=%0h/%0h exp=1/b1", resp_valid, resp_data); end
        start_fetch(32'h0000_2004);
        total++; if (cache_miss !== 1'b1 || resp_valid !== 1'b0) begin bad++; $display("FAIL flr_refetch_miss got=%0h/%0h exp=1/0", cache_miss, resp_valid); end
        drive_beat(1'b0, 32'hC0);
        drive_beat(1'b0, 32'hC1);
        drive_beat(1'b0, 32'hC2);
        drive_beat(1'b1, 32'hC3);
        total++; if (resp_valid !== 1'b1 || resp_data !== 32'hC1) begin bad++; $display("FAIL flr_refill2 got=%0h/%0h exp=1/c1", resp_valid, resp_data); end
        // Hit in the same cycle as an IDLE flush: served from pre-flush state
        fetch_valid = 1'b1;
        fetch_addr  = 32'h0000_2004;
        flush       = 1'b1;
        tick();
        fetch_valid = 1'b0;
        flush       = 1'b0;
        total++; if (resp_valid !== 1'b1 || resp_data !== 32'hC1 || cache_miss !== 1'b0) begin bad++; $display("FAIL idle_flush_hit got=%0h/%0h/%0h exp=1/c1/0", resp_valid, resp_data, cache_miss); end
        start_fetch(32'h0000_2004);
        total++; if (cache_miss !== 1'b1) begin bad++; $display("FAIL idle_flush_miss got=%0h exp=1", cache_miss); end
        drive_beat(1'b0, 32'hD0);
        drive_beat(1'b0, 32'hD1);
        drive_beat(1'b0, 32'hD2);
        drive_beat(1'b1, 32'hD3);
        total++; if (resp_valid !== 1'b1 || resp_data !== 32'hD1) begin bad++; $display("FAIL idle_flush_refill got=%0h/%0h exp=1/d1", resp_valid, resp_data); end
    endtask

    task automatic test_reset_mid_refill();
        start_fetch(32'h0000_1000);
        total++; if (cache_miss !== 1'b1) begin bad++; $display("FAIL rmr_miss got=%0h exp=1", cache_miss); end
        drive_beat(1'b0, 32'hE0);
        drive_beat(1'b0, 32'hE1);
        reset = 1'b0;
        #1;
        total++; if (resp_valid !== 1'b0 || cache_miss !== 1'b0 || fetch_ready !== 1'b0) begin bad++; $display("FAIL rmr_ctrl got=%0h/%0h/%0h exp=0/0/0", resp_valid, cache_miss, fetch_ready); end
        total++; if (resp_data !== 32'h0 || miss_addr !== 32'h0) begin bad++; $display("FAIL rmr_data got=%0h/%0h exp=0/0", resp_data, miss_addr); end
        tick();
        reset = 1'b1;
        tick();
        total++; if (fetch_ready !== 1'b1) begin bad++; $display("FAIL rmr_idle got=%0h exp=1", fetch_ready); end
        drive_beat(1'b1, 32'hEE);
        total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL rmr_stray got=%0h exp=0", resp_valid); end
        start_fetch(32'h0000_1000);
        total++; if (cache_miss !== 1'b1 || miss_addr !== 32'h0000_1000) begin bad++; $display("FAIL rmr_refetch got=%0h/%0h exp=1/1000", cache_miss, miss_addr); end
        drive_beat(1'b0, 32'hF0);
        drive_beat(1'b0, 32'hF1);
        drive_beat(1'b0, 32'hF2);
        drive_beat(1'b1, 32'hF3);
        total++; if (resp_valid !== 1'b1 || resp_data !== 32'hF0) begin bad++; $display("FAIL rmr_refill got=%0h/%0h exp=1/f0", resp_valid, resp_data); end
    endtask

    task automatic test_final_beat();
        logic [`XLEN-1:0] beats [3];
        beats[0] = 32'h51;
        beats[1] = 32'h52;
        beats[2] = 32'h53;
        start_fetch(32'h0000_300C);
        total++; if (cache_miss !== 1'b1 || miss_addr !== 32'h0000_300C) begin bad++; $display("FAIL fin_miss got=%0h/%0h exp=1/300c", cache_miss, miss_addr); end
        for (int i = 0; i < 3; i++) begin
            drive_beat(1'b0, beats[i]);
            total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL fin_no_resp_beat%0d got=%0h exp=0", i, resp_valid); end
        end
        drive_beat(1'b1, 32'h54);
        total++; if (resp_valid !== 1'b1 || resp_data !== 32'h54) begin bad++; $display("FAIL fin_resp got=%0h/%0h exp=1/54", resp_valid, resp_data); end
        start_fetch(32'h0000_3008);
        total++; if (resp_valid !== 1'b1 || resp_data !== 32'h53 || cache_miss !== 1'b0) begin bad++; $display("FAIL fin_hit got=%0h/%0h/%0h exp=1/53/0", resp_valid, resp_data, cache_miss); end
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        reset        = 1'b1;
        fetch_valid  = 1'b0;
        fetch_addr   = '0;
        flush        = 1'b0;
        refill_valid = 1'b0;
        refill_data  = '0;
        refill_done  = 1'b0;
        test_reset();
        test_cold_miss();
        test_back_to_back();
        test_conflict();
        test_flush_refill();
        test_reset_mid_refill();
        test_final_beat();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/icache_dm.md
Name: icache_dm

Overview:
- Direct-mapped instruction cache with 16-byte lines (4 words). Sits between the fetch stage and the refill cache controller.
- Serves fetch hits with 1-cycle latency.
- On a miss it:
  - pulses a miss request to the controller;
  - absorbs the 4-beat refill stream;
  - installs the line;
  - returns the requested word.
- Fetch is blocked for the duration of a refill.

Parameters:
- NUM_LINES, 64, number of cache lines. Must be a power of two and ≥ 2.
- IDX_BITS, log2(NUM_LINES), index width. Derived; never overridden.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- fetch_valid  input  1  fetch request present.
- fetch_addr  input  `XLEN  byte address of the instruction. Bits [1:0] are ignored.
- fetch_ready  output  1  cache can accept a fetch this cycle.
- resp_valid  output  1  resp_data is valid this cycle. Single-cycle pulse per request; no backpressure.
- resp_data  output  `XLEN  fetched instruction word.
- flush  input  1  invalidate all lines (fence.i).
- cache_miss  output  1  one-cycle miss pulse to the refill controller.
- miss_addr  output  `XLEN  full miss address. The controller line-aligns it.
- refill_valid  input  1  refill_data carries refill beat 0, 1 or 2.
- refill_data  input  `XLEN  refill word.
- refill_done  input  1  refill_data carries final beat 3; line complete.

Behaviour:
- Address split:
  - offset = addr[3:2]
  - index = addr[IDX_BITS+3:4]
  - tag = addr[`XLEN-1:IDX_BITS+4]
- Storage:
  - valid bit per line.
  - Tag per line.
  - 4 words per line.
  - All arrays are flop-based; reads are combinational from fetch_addr.
- Reset (reset=0, async):
  - state=IDLE.
  - All valid bits cleared.
  - Outputs: fetch_ready=0 while reset is asserted, then 1 in IDLE.
  - resp_valid=0, resp_data=0, cache_miss=0, miss_addr=0.
  - Beat counter=0; flush_pending=0.
  - Tag/data contents are don't-care.
- FSM states: IDLE, REFILL.
- IDLE:
  - fetch_ready=1.
  - Handshake: the request is accepted when fetch_valid & fetch_ready.
  - Hit (valid[index] & tag match):
    - Next cycle: resp_valid=1 and resp_data=data[index][offset].
    - State stays IDLE, so back-to-back hits sustain 1 fetch/cycle.
  - Miss:
    - Next cycle: cache_miss=1 (exactly one cycle) and miss_addr=fetch_addr.
    - Latch index, tag and offset; clear the beat counter.
    - Enter REFILL. resp_valid=0.
  - No acceptance: resp_valid=0 next cycle.
  - refill_valid/refill_done are ignored in IDLE (stray beats are discarded).
- REFILL:
  - fetch_ready=0; cache_miss=0 after the first cycle.
  - refill_valid=1:
    - Write refill_data into data[latched index][beat counter].
    - If beat counter == latched offset, capture the word into the critical-word register.
    - Increment the counter (2-bit).
  - refill_done=1:
    - Write refill_data as beat 3. The slot used is the counter value; the counter is expected to be 3.
    - Write the tag.
    - Set valid unless flush_pending.
    - Next cycle: resp_valid=1, with resp_data = refill_data if offset==3, else the critical-word register.
    - Clear the counter and flush_pending; return to IDLE.
  - refill_done arriving with counter≠3 is a protocol error. The line is still installed on refill_done and the FSM still returns to IDLE; this is not recovered further.
  - refill_valid and refill_done never coincide. If they do, refill_done takes priority.
  - Beat gaps of any length are tolerated: cycles with neither strobe do nothing.
- Flush:
  - In IDLE: all valid bits clear at the next edge.
    - A fetch accepted in the same cycle as flush is looked up against the pre-flush state, and the looked-up line is not re-validated.
  - In REFILL: all valid bits clear immediately and flush_pending=1. The in-flight line is written but left invalid; its response is still delivered.
- Miss latency: fetch accept → cache_miss (+1) → controller beats → resp_valid one cycle after refill_done.
- Reset mid-refill: the FSM returns to IDLE, the counter clears and no response is issued. Any later beats arrive in IDLE and are ignored.

Test Plan:
1. Cold miss, addr 0x0000_1008:
   - Expect cache_miss pulse 1 cycle with miss_addr=0x0000_1008; fetch_ready=0.
   - Drive beats 0x11,0x22,0x33 on refill_valid, then 0x44 on refill_done.
   - Expect resp_valid=1 with resp_data=0x33 one cycle later; fetch_ready=1.
2. After test 1, fetch 0x1000, 0x1004, 0x100C on consecutive cycles:
   - Expect resp_data 0x11, 0x22, 0x44 on 3 consecutive cycles.
   - Expect no cache_miss.
3. Conflict: fetch 0x0000_1400 (same index as 0x1000, NUM_LINES=64):
   - Expect a miss and refill.
   - Then 0x1000 misses again (eviction verified).
4. Flush during refill, gapped beats:
   - Miss 0x2004; beats separated by 2 idle cycles; assert flush before refill_done.
   - Expect resp_data = beat 1.
   - A re-fetch of 0x2004 must miss.
5. Reset mid-refill:
   - Assert reset after beat 1.
   - Expect all outputs 0 and IDLE.
   - A subsequent stray refill_done must produce no resp_valid; a fetch of 0x1000 must miss.
6. Final beat selected: miss 0x300C.
   - Expect resp_data = refill_data of the refill_done beat.
   - Expect no response on beats 0-2.
